dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage (core) and an external loader/debug master (ext).
- Core has fixed priority. A starvation counter forces an ext slot after MAX_WAIT lost cycles, and an optional lock lets ext run short bursts.
- While ext owns the port, the arbiter stalls the core.
- Sits between the EX/MEM register outputs and the datamemory instance.

Parameters:
- DATA_W, 32, data width
- DM_ADDRESS, 9, memory address width
- MAX_WAIT, 4, consecutive cycles ext may lose to core before a forced ext slot (>=1)
- LOCK_MAX, 8, maximum cycles of one locked ext burst (>=1)

Ports:
- clk in 1 clock
- reset in 1 async active-high reset
- core_rd in 1 core MemRead
- core_wr in 1 core MemWrite
- core_addr in DM_ADDRESS core address
- core_wdata in DATA_W core store data
- core_func3 in 3 core access size/sign
- core_rdata out DATA_W core load data
- core_stall out 1 core access not performed this cycle; hold pipeline
- ext_req in 1 ext access request
- ext_we in 1 ext write (1) / read (0)
- ext_lock in 1 ext requests to keep the port after this access
- ext_addr in DM_ADDRESS ext address
- ext_wdata in DATA_W ext store data
- ext_gnt out 1 ext access performed this cycle
- ext_rvalid out 1 ext_rdata valid (one cycle after a granted read)
- ext_rdata out DATA_W registered ext load data
- mem_rd out 1 to datamemory MemRead
- mem_wr out 1 to datamemory MemWrite
- mem_addr out DM_ADDRESS to datamemory address
- mem_wdata out DATA_W to datamemory write data
- mem_func3 out 3 to datamemory func3
- mem_rdata in DATA_W from datamemory (combinational read, synchronous write)

Behaviour:
- Interface: one clock clk. Reset is named reset, asynchronous and active-high.
- Reset values:
  - state = S_CORE; wait_cnt = 0; lock_cnt = 0.
  - ext_rvalid = 0; ext_rdata = 0.
  - All combinational outputs take their S_CORE idle values: mem_rd/mem_wr/ext_gnt/core_stall = 0.
- core_req = core_rd | core_wr.
- Each cycle exactly one owner drives the mem_* outputs. The default owner is core with all mem_* driven from core_*.
- S_CORE:
  - core_req=1: core served (core_stall=0, ext_gnt=0). If ext_req, wait_cnt increments, saturating at MAX_WAIT.
  - core_req=0 and ext_req=1: ext served this cycle (ext_gnt=1). wait_cnt clears. If ext_lock=1, go to S_LOCK with lock_cnt=1.
  - wait_cnt==MAX_WAIT and ext_req=1: go to S_EXT next cycle.
  - ext_req=0: wait_cnt clears.
- S_EXT (forced slot):
  - ext served; core_stall = core_req.
  - wait_cnt clears.
  - Next state is S_LOCK if ext_lock=1 (lock_cnt=1), else S_CORE.
  - If ext_req dropped before this cycle: no ext access, core served, return to S_CORE.
- S_LOCK:
  - ext served while ext_req=1; core_stall = core_req. lock_cnt increments each cycle.
  - Exit to S_CORE when ext_lock=0, ext_req=0, or lock_cnt==LOCK_MAX. On a LOCK_MAX exit, the current access is still served.
  - wait_cnt stays 0 for the first cycle after exit, giving core a guaranteed slot.
- Ext grant and read data:
  - ext_gnt is combinational and the same cycle as the access. ext must hold its request fields until ext_gnt.
  - Ext read: ext_rdata <= mem_rdata and ext_rvalid <= 1 at the clock edge ending the grant cycle. ext_rvalid=0 otherwise.
- Stalled core: core_rdata = mem_rdata whenever core owns the port. Under stall, core_rdata is don't-care and the core must hold its request stable.
- Simultaneous core and ext write: only the owner writes; the other write is never issued.
- Reset mid-burst: immediate return to reset state. A pending ext_rvalid is dropped.

Optional Feature:
- Macro: DMEM_PORT_ARBITER_STATS_EN.
- With the macro:
  - 32-bit saturating counters stall_cycles (increments when core_stall=1) and ext_grants (increments on ext_gnt).
  - Exposed on outputs stat_stall and stat_ext. Both reset to 0.
- Without the macro: the ports still exist, tied to 0, and no counters are inferred.

Test Plan:
- Core only: core_wr=1 at addr 0x10 with 0xDEADBEEF, then core_rd at 0x10. Required: mem_wr passthrough, core_rdata=0xDEADBEEF the same cycle, core_stall never 1.
- Idle core: ext read at 0x10. Required: ext_gnt=1 that cycle; ext_rvalid=1 and ext_rdata=0xDEADBEEF the next cycle.
- Starvation: core_rd every cycle with ext_req held and MAX_WAIT=4. Required: ext_gnt=0 for 4 cycles; on the 5th cycle ext_gnt=1 and core_stall=1; on the 6th cycle core_stall=0.
- Lock: ext_lock=1 with 12 ext writes, core_req constantly 1, LOCK_MAX=8. Required: 8 consecutive grants with core_stall=1, then at least one core cycle with core_stall=0 before the next ext grant.
- Reset asserted mid-lock: required on the same edge, ext_gnt=0, core_stall=0, ext_rvalid=0; after release the state is S_CORE.
- Stats build: in the starvation scenario, required stat_stall=1 and stat_ext=1 after the forced slot.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// Signal bundle between the MEM stage, the external loader/debug master and the data memory.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface dmem_port_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
);
  // core (EX/MEM register outputs)
  logic                  core_rd;
  logic                  core_wr;
  logic [DM_ADDRESS-1:0] core_addr;
  logic [DATA_W-1:0]     core_wdata;
  logic [2:0]            core_func3;
  logic [DATA_W-1:0]     core_rdata;
  logic                  core_stall;

  // external loader / debug master
  logic                  ext_req;
  logic                  ext_we;
  logic                  ext_lock;
  logic [DM_ADDRESS-1:0] ext_addr;
  logic [DATA_W-1:0]     ext_wdata;
  logic                  ext_gnt;
  logic                  ext_rvalid;
  logic [DATA_W-1:0]     ext_rdata;

  // datamemory side
  logic                  mem_rd;
  logic                  mem_wr;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_func3;
  logic [DATA_W-1:0]     mem_rdata;

  // statistics (zero when the counters are not built)
  logic [31:0]           stat_stall;
  logic [31:0]           stat_ext;

  modport slave (
    input  core_rd, core_wr, core_addr, core_wdata, core_func3,
    output core_rdata, core_stall,
    input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
    input  mem_rdata,
    output stat_stall, stat_ext
  );

  modport master (
    output core_rd, core_wr, core_addr, core_wdata, core_func3,
    input  core_rdata, core_stall,
    output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
    output mem_rdata,
    input  stat_stall, stat_ext
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: core has fixed priority, ext gets forced slots after MAX_WAIT
// lost cycles plus optional locked bursts. Counters built with DMEM_PORT_ARBITER_STATS_EN.
module dmem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int MAX_WAIT   = 4,
  parameter int LOCK_MAX   = 8
) (
  input logic                clk,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
);

  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam int                LOCK_W    = $clog2(LOCK_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_TOP  = WAIT_W'(MAX_WAIT);
  localparam logic [LOCK_W-1:0] LOCK_TOP  = LOCK_W'(LOCK_MAX);
  localparam logic [2:0]        EXT_FUNC3 = 3'b010;
  // A one-access burst never needs the lock state.
  localparam bit                LOCK_OK   = (LOCK_MAX > 1);

  typedef enum logic [1:0] {
    S_CORE = 2'd0,
    S_EXT  = 2'd1,
    S_LOCK = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                hold_q, hold_d;
  logic                ext_rvalid_q;
  logic [DATA_W-1:0]   ext_rdata_q;

  logic                core_req;
  logic                ext_own;
  logic                ext_gnt;
  logic                core_stall;
  logic [WAIT_W-1:0]   wait_inc;
  logic [LOCK_W-1:0]   lock_inc;

  assign core_req = bus.core_rd | bus.core_wr;
  assign wait_inc = (wait_cnt_q == WAIT_TOP) ? WAIT_TOP : wait_cnt_q + 1'b1;
  assign lock_inc = lock_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_CORE;
      wait_cnt_q <= '0;
      lock_cnt_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lock_cnt_d = lock_cnt_q;
    hold_d     = 1'b0;
    ext_own    = 1'b0;
    unique case (state_q)
      S_CORE: begin
        if (core_req) begin
          // hold_q: first cycle after a burst, core's slot does not count against ext
          if (!bus.ext_req || hold_q) begin
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_inc;
            if (wait_inc == WAIT_TOP) begin
              state_d = S_EXT;
            end
          end
        end else if (bus.ext_req) begin
          ext_own    = 1'b1;
          wait_cnt_d = '0;
          if (bus.ext_lock && LOCK_OK) begin
            state_d    = S_LOCK;
            lock_cnt_d = LOCK_W'(1);
          end
        end else begin
          wait_cnt_d = '0;
        end
      end

      S_EXT: begin
        wait_cnt_d = '0;
        state_d    = S_CORE;
        if (bus.ext_req) begin
          ext_own = 1'b1;
          if (bus.ext_lock && LOCK_OK) begin
            state_d    = S_LOCK;
            lock_cnt_d = LOCK_W'(1);
          end
        end
      end

      S_LOCK: begin
        wait_cnt_d = '0;
        lock_cnt_d = lock_inc;
        if (bus.ext_req) begin
          ext_own = 1'b1;
        end
        // lock_cnt counts grants of the burst including the one that entered the lock
        if (!bus.ext_req || !bus.ext_lock || lock_inc == LOCK_TOP) begin
          state_d    = S_CORE;
          lock_cnt_d = '0;
          hold_d     = 1'b1;
        end
      end

      default: begin
        state_d    = S_CORE;
        wait_cnt_d = '0;
        lock_cnt_d = '0;
      end
    endcase
  end

  assign ext_gnt    = ext_own & ~reset;
  assign core_stall = ext_own & core_req & ~reset;

  // Exactly one owner drives the memory port; the loser's write never reaches it.
  assign bus.mem_rd    = ~reset & (ext_own ? ~bus.ext_we : bus.core_rd);
  assign bus.mem_wr    = ~reset & (ext_own ?  bus.ext_we : bus.core_wr);
  assign bus.mem_addr  = ext_own ? bus.ext_addr  : bus.core_addr;
  assign bus.mem_wdata = ext_own ? bus.ext_wdata : bus.core_wdata;
  assign bus.mem_func3 = ext_own ? EXT_FUNC3     : bus.core_func3;

  assign bus.core_rdata = bus.mem_rdata;
  assign bus.core_stall = core_stall;
  assign bus.ext_gnt    = ext_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      ext_rvalid_q <= ext_gnt & ~bus.ext_we;
      if (ext_gnt && !bus.ext_we) begin
        ext_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.ext_rvalid = ext_rvalid_q;
  assign bus.ext_rdata  = ext_rdata_q;

`ifdef DMEM_PORT_ARBITER_STATS_EN
  // Index 0 counts stalled core cycles, index 1 counts ext grants; both saturate.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_stat
    logic        inc;
    logic [31:0] cnt_q;

    assign inc = (gi == 0) ? core_stall : ext_gnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (inc && cnt_q != 32'hFFFF_FFFF) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign bus.stat_stall = g_stat[0].cnt_q;
  assign bus.stat_ext   = g_stat[1].cnt_q;
`else
  assign bus.stat_stall = '0;
  assign bus.stat_ext   = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: core passthrough, idle-core ext read, starvation,
// locked burst, reset mid-lock, and the statistics outputs.
module tb_dmem_port_arbiter;

  localparam int DATA_W     = 32;
  localparam int DM_ADDRESS = 9;
`ifdef DMEM_PORT_ARBITER_STATS_EN
  localparam logic [31:0] STAT_ONE = 32'd1;
`else
  localparam logic [31:0] STAT_ONE = 32'd0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [DATA_W-1:0] mem [512];

  dmem_port_arbiter_if #(.DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS)) bus ();

  dmem_port_arbiter #(
    .DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS), .MAX_WAIT(4), .LOCK_MAX(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Data memory model: combinational read, synchronous write.
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.core_rd    = 1'b0;
    bus.core_wr    = 1'b0;
    bus.core_addr  = '0;
    bus.core_wdata = '0;
    bus.core_func3 = 3'b010;
    bus.ext_req    = 1'b0;
    bus.ext_we     = 1'b0;
    bus.ext_lock   = 1'b0;
    bus.ext_addr   = '0;
    bus.ext_wdata  = '0;
  endtask

  // Called just after a rising edge; leaves the bench just after the next rising edge.
  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [20:0] lock_exp;
  int          k;

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 512; i++) mem[i] <= '0;
    mem[9'h20] <= 32'h1234_5678;
    reset = 1'b1;
    idle_inputs();

    // Reset state
    @(negedge clk);
    chk("rst_ext_gnt", bus.ext_gnt, 0);
    chk("rst_core_stall", bus.core_stall, 0);
    chk("rst_ext_rvalid", bus.ext_rvalid, 0);
    chk("rst_ext_rdata", bus.ext_rdata, 0);
    chk("rst_mem_wr", bus.mem_wr, 0);
    chk("rst_stat_stall", bus.stat_stall, 0);
    chk("rst_stat_ext", bus.stat_ext, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Core store passthrough
    bus.core_wr = 1'b1; bus.core_addr = 9'h10; bus.core_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("core_wr_mem_wr", bus.mem_wr, 1);
    chk("core_wr_mem_addr", bus.mem_addr, 32'h10);
    chk("core_wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("core_wr_stall", bus.core_stall, 0);
    @(posedge clk);
    #1;

    // Core load, same-cycle data
    bus.core_wr = 1'b0; bus.core_rd = 1'b1;
    @(negedge clk);
    chk("core_rd_rdata", bus.core_rdata, 32'hDEAD_BEEF);
    chk("core_rd_mem_rd", bus.mem_rd, 1);
    chk("core_rd_mem_wr", bus.mem_wr, 0);
    chk("core_rd_stall", bus.core_stall, 0);
    @(posedge clk);
    #1;

    // Idle core: ext read
    bus.core_rd = 1'b0; bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 9'h10;
    @(negedge clk);
    chk("ext_rd_gnt", bus.ext_gnt, 1);
    chk("ext_rd_mem_addr", bus.mem_addr, 32'h10);
    chk("ext_rd_func3", bus.mem_func3, 32'h2);
    chk("ext_rd_rvalid_early", bus.ext_rvalid, 0);
    @(posedge clk);
    #1;
    bus.ext_req = 1'b0;
    @(negedge clk);
    chk("ext_rd_rvalid", bus.ext_rvalid, 1);
    chk("ext_rd_rdata", bus.ext_rdata, 32'hDEAD_BEEF);
    chk("ext_rd_gnt_after", bus.ext_gnt, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ext_rd_rvalid_drop", bus.ext_rvalid, 0);
    @(posedge clk);
    #1;

    // Starvation: ext loses four cycles, wins the fifth
    do_reset();
    bus.core_rd = 1'b1; bus.core_addr = 9'h10;
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 9'h20;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("starve_gnt_c%0d", c), bus.ext_gnt, 0);
      chk($sformatf("starve_stall_c%0d", c), bus.core_stall, 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("starve_gnt_c5", bus.ext_gnt, 1);
    chk("starve_stall_c5", bus.core_stall, 1);
    chk("starve_addr_c5", bus.mem_addr, 32'h20);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("starve_gnt_c6", bus.ext_gnt, 0);
    chk("starve_stall_c6", bus.core_stall, 0);
    chk("starve_rvalid_c6", bus.ext_rvalid, 1);
    chk("starve_rdata_c6", bus.ext_rdata, 32'h1234_5678);
    chk("starve_stat_stall", bus.stat_stall, STAT_ONE);
    chk("starve_stat_ext", bus.stat_ext, STAT_ONE);
    @(posedge clk);
    #1;

    // Locked burst of 12 ext writes against a constantly requesting core
    do_reset();
    lock_exp = 21'b1111_00000_11111111_0000;
    k = 0;
    bus.core_rd = 1'b1; bus.core_addr = 9'h10;
    for (int c = 1; c <= 21; c++) begin
      bus.ext_req   = (k < 12);
      bus.ext_we    = 1'b1;
      bus.ext_lock  = (k < 11);
      bus.ext_addr  = 9'h40 + 9'(k);
      bus.ext_wdata = 32'hA000_0000 + 32'(k);
      @(negedge clk);
      chk($sformatf("lock_gnt_c%0d", c), bus.ext_gnt, 32'(lock_exp[c-1]));
      chk($sformatf("lock_stall_c%0d", c), bus.core_stall, 32'(lock_exp[c-1]));
      chk($sformatf("lock_mem_wr_c%0d", c), bus.mem_wr, 32'(lock_exp[c-1]));
      if (bus.ext_gnt === 1'b1) k++;
      @(posedge clk);
      #1;
    end
    bus.ext_req = 1'b0; bus.ext_lock = 1'b0;
    chk("lock_writes_done", k, 12);
    chk("lock_mem_w0", mem[9'h40], 32'hA000_0000);
    chk("lock_mem_w7", mem[9'h47], 32'hA000_0007);
    chk("lock_mem_w8", mem[9'h48], 32'hA000_0008);
    chk("lock_mem_w11", mem[9'h4B], 32'hA000_000B);

    // Reset asserted in the middle of a locked read burst
    do_reset();
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_lock = 1'b1; bus.ext_addr = 9'h10;
    @(negedge clk);
    chk("mid_gnt_a", bus.ext_gnt, 1);
    @(posedge clk);
    #1;
    bus.core_rd = 1'b1; bus.core_addr = 9'h30;
    @(negedge clk);
    chk("mid_gnt_b", bus.ext_gnt, 1);
    chk("mid_stall_b", bus.core_stall, 1);
    chk("mid_rvalid_b", bus.ext_rvalid, 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", bus.ext_gnt, 0);
    chk("mid_rst_stall", bus.core_stall, 0);
    chk("mid_rst_rvalid", bus.ext_rvalid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt", bus.ext_gnt, 0);
    chk("post_rst_stall", bus.core_stall, 0);
    chk("post_rst_mem_addr", bus.mem_addr, 32'h30);
    chk("post_rst_mem_rd", bus.mem_rd, 1);
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
